// File: rtl/event_decoder_if.sv
// Bundle of the event input stream and the decoded-event output stream of event_decoder.
// The master modport drives the input words and evt_ready_i; the slave modport is the decoder.
interface event_decoder_if #(
    parameter int ROW_ADD = 3,
    parameter int COL_ADD = 3,
    parameter int TS_W    = 8,
    parameter int EPOCH_W = 8
);
    localparam int WIDTH = ROW_ADD + COL_ADD + TS_W + 1;

    // Input side has no backpressure: a word is taken on every edge where valid_i=1.
    // Output side is valid/ready: the head transfers on an edge where evt_valid_o=1 and
    // evt_ready_i=1; the head stays stable while evt_valid_o=1 and evt_ready_i=0.
    logic                     valid_i;
    logic [WIDTH-1:0]         data_i;
    logic                     evt_ready_i;
    logic                     evt_valid_o;
    logic [ROW_ADD-1:0]       x_o;
    logic [COL_ADD-1:0]       y_o;
    logic [EPOCH_W+TS_W-1:0]  ts_o;
    logic                     pol_o;
    logic                     overflow_o;
    logic [7:0]               drop_cnt_o;
    logic [15:0]              on_cnt_o;
    logic [15:0]              off_cnt_o;

    modport master (
        output valid_i, data_i, evt_ready_i,
        input  evt_valid_o, x_o, y_o, ts_o, pol_o, overflow_o, drop_cnt_o, on_cnt_o, off_cnt_o
    );

    modport slave (
        input  valid_i, data_i, evt_ready_i,
        output evt_valid_o, x_o, y_o, ts_o, pol_o, overflow_o, drop_cnt_o, on_cnt_o, off_cnt_o
    );
endinterface

// File: rtl/event_decoder.sv
// Event word decoder: capture, split, extend timestamp with a local epoch, buffer in a FIFO.
// Optional macro EVT_DEDUP_EN drops a decoded word identical to the previously enqueued one.
module event_decoder #(
    parameter int ROW_ADD = 3,
    parameter int COL_ADD = 3,
    parameter int TS_W    = 8,
    parameter int EPOCH_W = 8,
    parameter int DEPTH   = 4
) (
    input logic           clk_i,
    input logic           reset_i,
    event_decoder_if.slave bus
);
    localparam int WIDTH   = ROW_ADD + COL_ADD + TS_W + 1;
    localparam int ENTRY_W = ROW_ADD + COL_ADD + EPOCH_W + TS_W + 1;
    localparam int AW      = $clog2(DEPTH);

    logic               dec_valid;
    logic [WIDTH-1:0]   dec_word;
    logic [ROW_ADD-1:0] dec_row;
    logic [COL_ADD-1:0] dec_col;
    logic [TS_W-1:0]    dec_ts;
    logic               dec_pol;

    logic [TS_W-1:0]    last_ts;
    logic [EPOCH_W-1:0] epoch;
    logic [EPOCH_W-1:0] next_epoch;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic               empty;
    logic               full;

    logic               dup;
    logic               push_req;
    logic               push_ok;
    logic               drop;
    logic               pop;

    logic               overflow;
    logic [7:0]         drop_cnt;
    logic [15:0]        on_cnt;
    logic [15:0]        off_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dec_valid <= 1'b0;
            dec_word  <= '0;
        end else begin
            dec_valid <= bus.valid_i;
            if (bus.valid_i)
                dec_word <= bus.data_i;
        end
    end

    assign dec_row = dec_word[WIDTH-1 -: ROW_ADD];
    assign dec_col = dec_word[WIDTH-1-ROW_ADD -: COL_ADD];
    assign dec_ts  = dec_word[TS_W:1];
    assign dec_pol = dec_word[0];

    // A timestamp going backwards means the sender's counter wrapped.
    assign next_epoch = epoch + EPOCH_W'(dec_ts < last_ts);

`ifdef EVT_DEDUP_EN
    logic             last_valid;
    logic [WIDTH-1:0] last_word;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_valid <= 1'b0;
            last_word  <= '0;
        end else if (push_ok) begin
            last_valid <= 1'b1;
            last_word  <= dec_word;
        end
    end

    assign dup = last_valid && (last_word == dec_word);
`else
    assign dup = 1'b0;
`endif

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && bus.evt_ready_i;
    assign push_req = dec_valid && !dup;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= {dec_row, dec_col, next_epoch, dec_ts, dec_pol};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_ts  <= '0;
            epoch    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            on_cnt   <= '0;
            off_cnt  <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) begin
                wr_ptr  <= wr_ptr + 1'b1;
                last_ts <= dec_ts;
                epoch   <= next_epoch;
                if (dec_pol)
                    on_cnt <= on_cnt + 16'd1;
                else
                    off_cnt <= off_cnt + 16'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

    assign bus.evt_valid_o = !empty;
    assign bus.x_o         = empty ? '0 : head[ENTRY_W-1 -: ROW_ADD];
    assign bus.y_o         = empty ? '0 : head[ENTRY_W-1-ROW_ADD -: COL_ADD];
    assign bus.ts_o        = empty ? '0 : head[EPOCH_W+TS_W:1];
    assign bus.pol_o       = empty ? 1'b0 : head[0];
    assign bus.overflow_o  = overflow;
    assign bus.drop_cnt_o  = drop_cnt;
    assign bus.on_cnt_o    = on_cnt;
    assign bus.off_cnt_o   = off_cnt;
endmodule

// File: tb/tb_event_decoder.sv
// Self-checking bench for event_decoder: decode table, timestamp wrap, overflow, full push+pop,
// duplicate words and mid-stream reset, with a scoreboard on the output stream.
module tb_event_decoder;
    localparam int ROW_ADD = 3;
    localparam int COL_ADD = 3;
    localparam int TS_W    = 8;
    localparam int EPOCH_W = 8;
    localparam int DEPTH   = 4;
    localparam int WIDTH   = ROW_ADD + COL_ADD + TS_W + 1;
    localparam int W       = ROW_ADD + COL_ADD + EPOCH_W + TS_W + 1;

    logic clk_i = 1'b0;
    logic reset_i;

    always #5 clk_i = ~clk_i;

    event_decoder_if #(.ROW_ADD(ROW_ADD), .COL_ADD(COL_ADD), .TS_W(TS_W), .EPOCH_W(EPOCH_W)) bus ();

    event_decoder #(
        .ROW_ADD(ROW_ADD), .COL_ADD(COL_ADD), .TS_W(TS_W), .EPOCH_W(EPOCH_W), .DEPTH(DEPTH)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0]  row;
        logic [2:0]  col;
        logic [7:0]  ts;
        logic        pol;
        logic [15:0] exp_ts;
    } vec_t;

    vec_t          vecs[5];
    logic [W-1:0]  exp_q[$];
    int            n_checks  = 0;
    int            n_fail    = 0;
    int            pop_count = 0;
    int            exp_on    = 0;
    int            exp_off   = 0;
    int            pops_before;

    function automatic logic [WIDTH-1:0] mk(input logic [2:0] row, input logic [2:0] col,
                                            input logic [7:0] ts, input logic pol);
        return {row, col, ts, pol};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_evt(input logic [2:0] x, input logic [2:0] y,
                              input logic [15:0] ts, input logic pol);
        exp_q.push_back({x, y, ts, pol});
        if (pol) exp_on++;
        else     exp_off++;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++)
            step();
        check("drain_left", exp_q.size(), 0);
    endtask

    // Scoreboard: every accepted head must match the oldest expected event.
    always @(negedge clk_i) begin
        logic [W-1:0] e;
        if (!reset_i && bus.evt_valid_o && bus.evt_ready_i) begin
            pop_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got 0x%0h, expected no event at %0t",
                         {bus.x_o, bus.y_o, bus.ts_o, bus.pol_o}, $time);
            end else begin
                e = exp_q.pop_front();
                check("pop_word", {bus.x_o, bus.y_o, bus.ts_o, bus.pol_o}, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{row: 3'd1, col: 3'd2, ts: 8'h20, pol: 1'b0, exp_ts: 16'h0020};
        vecs[1] = '{row: 3'd7, col: 3'd7, ts: 8'hF0, pol: 1'b1, exp_ts: 16'h00F0};
        vecs[2] = '{row: 3'd0, col: 3'd3, ts: 8'h05, pol: 1'b0, exp_ts: 16'h0105};
        vecs[3] = '{row: 3'd6, col: 3'd1, ts: 8'h05, pol: 1'b1, exp_ts: 16'h0105};
        vecs[4] = '{row: 3'd2, col: 3'd5, ts: 8'h04, pol: 1'b1, exp_ts: 16'h0204};

        reset_i         = 1'b1;
        bus.valid_i     = 1'b0;
        bus.data_i      = '0;
        bus.evt_ready_i = 1'b0;
        repeat (3) step();
        check("rst_evt_valid", bus.evt_valid_o, 0);
        check("rst_x", bus.x_o, 0);
        check("rst_ts", bus.ts_o, 0);
        check("rst_pol", bus.pol_o, 0);
        check("rst_overflow", bus.overflow_o, 0);
        check("rst_drop_cnt", bus.drop_cnt_o, 0);
        check("rst_on_cnt", bus.on_cnt_o, 0);
        check("rst_off_cnt", bus.off_cnt_o, 0);
        reset_i = 1'b0;
        step();

        // Single event 0x5421: two-cycle latency, one-cycle presentation.
        bus.evt_ready_i = 1'b1;
        bus.data_i      = WIDTH'(15'h5421);
        bus.valid_i     = 1'b1;
        expect_evt(3'd5, 3'd2, 16'h0010, 1'b1);
        step();
        bus.valid_i = 1'b0;
        check("single_lat1_valid", bus.evt_valid_o, 0);
        step();
        check("single_valid", bus.evt_valid_o, 1);
        check("single_x", bus.x_o, 5);
        check("single_y", bus.y_o, 2);
        check("single_ts", bus.ts_o, 16'h0010);
        check("single_pol", bus.pol_o, 1);
        step();
        check("single_valid_drop", bus.evt_valid_o, 0);
        check("single_on_cnt", bus.on_cnt_o, 1);

        // Decode table streamed back to back, including a timestamp wrap.
        for (int i = 0; i < 5; i++) begin
            bus.data_i  = mk(vecs[i].row, vecs[i].col, vecs[i].ts, vecs[i].pol);
            bus.valid_i = 1'b1;
            expect_evt(vecs[i].row, vecs[i].col, vecs[i].exp_ts, vecs[i].pol);
            step();
        end
        bus.valid_i = 1'b0;
        wait_drain(20);
        step();
        check("table_idle", bus.evt_valid_o, 0);
        check("table_on_cnt", bus.on_cnt_o, exp_on);
        check("table_off_cnt", bus.off_cnt_o, exp_off);

        // Overflow: six events into a four-entry FIFO with no reader.
        bus.evt_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.data_i  = mk(3'(i), 3'(5 - i), 8'(8'h10 + i), 1'(i));
            bus.valid_i = 1'b1;
            if (i < 4) expect_evt(3'(i), 3'(5 - i), 16'h0210 + 16'(i), 1'(i));
            step();
        end
        bus.valid_i = 1'b0;
        step();
        step();
        check("ovf_drop_cnt", bus.drop_cnt_o, 2);
        check("ovf_flag", bus.overflow_o, 1);
        check("ovf_valid", bus.evt_valid_o, 1);
        check("ovf_on_cnt", bus.on_cnt_o, exp_on);
        check("ovf_off_cnt", bus.off_cnt_o, exp_off);
        bus.evt_ready_i = 1'b1;
        wait_drain(20);
        step();
        check("ovf_idle", bus.evt_valid_o, 0);

        // Full FIFO: push and pop on the same edge must not drop.
        bus.evt_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.data_i  = mk(3'd3, 3'(i), 8'(8'h14 + i), 1'b1);
            bus.valid_i = 1'b1;
            expect_evt(3'd3, 3'(i), 16'h0214 + 16'(i), 1'b1);
            step();
        end
        bus.valid_i = 1'b0;
        step();
        step();
        bus.data_i  = mk(3'd4, 3'd4, 8'h18, 1'b0);
        bus.valid_i = 1'b1;
        expect_evt(3'd4, 3'd4, 16'h0218, 1'b0);
        step();
        bus.valid_i     = 1'b0;
        bus.evt_ready_i = 1'b1;
        step();
        bus.evt_ready_i = 1'b0;
        step();
        check("full_pp_drop_cnt", bus.drop_cnt_o, 2);
        check("full_pp_valid", bus.evt_valid_o, 1);
        pops_before     = pop_count;
        bus.evt_ready_i = 1'b1;
        wait_drain(20);
        check("full_pp_occupancy", pop_count - pops_before, 4);
        check("full_pp_on_cnt", bus.on_cnt_o, exp_on);
        check("full_pp_off_cnt", bus.off_cnt_o, exp_off);

        // Same word twice in a row.
        bus.data_i  = WIDTH'(15'h5421);
        bus.valid_i = 1'b1;
        expect_evt(3'd5, 3'd2, 16'h0310, 1'b1);
        step();
`ifndef EVT_DEDUP_EN
        expect_evt(3'd5, 3'd2, 16'h0310, 1'b1);
`endif
        step();
        bus.valid_i = 1'b0;
        wait_drain(20);
        step();
        check("dup_idle", bus.evt_valid_o, 0);
        check("dup_on_cnt", bus.on_cnt_o, exp_on);
        check("dup_drop_cnt", bus.drop_cnt_o, 2);

        // Reset with three events buffered: everything clears at once.
        bus.evt_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.data_i  = mk(3'd1, 3'(i), 8'(8'h40 + i), 1'b1);
            bus.valid_i = 1'b1;
            step();
        end
        bus.valid_i = 1'b0;
        step();
        step();
        check("pre_rst_valid", bus.evt_valid_o, 1);
        reset_i = 1'b1;
        #1;
        check("mid_rst_valid", bus.evt_valid_o, 0);
        check("mid_rst_ts", bus.ts_o, 0);
        check("mid_rst_on_cnt", bus.on_cnt_o, 0);
        check("mid_rst_off_cnt", bus.off_cnt_o, 0);
        check("mid_rst_overflow", bus.overflow_o, 0);
        check("mid_rst_drop_cnt", bus.drop_cnt_o, 0);
        exp_q.delete();
        exp_on  = 0;
        exp_off = 0;
        step();
        reset_i = 1'b0;
        step();

        // First event after reset sees a fresh epoch and timestamp history.
        bus.evt_ready_i = 1'b1;
        bus.data_i      = WIDTH'(15'h5421);
        bus.valid_i     = 1'b1;
        expect_evt(3'd5, 3'd2, 16'h0010, 1'b1);
        step();
        bus.valid_i = 1'b0;
        wait_drain(20);
        check("post_rst_on_cnt", bus.on_cnt_o, 1);
        check("post_rst_off_cnt", bus.off_cnt_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/event_decoder.md
EVENT_DECODER -- requirements
Module: event_decoder

Interface
REQ-001 Parameter ROW_ADD, default 3, row address width of an event word.
REQ-002 Parameter COL_ADD, default 3, column address width of an event word.
REQ-003 Parameter TS_W, default 8, timestamp width carried in an event word.
REQ-004 Parameter EPOCH_W, default 8, width of the locally generated timestamp-extension epoch.
REQ-005 Parameter DEPTH, default 4, output FIFO depth in entries (power of two).
REQ-006 Localparam WIDTH = ROW_ADD+COL_ADD+TS_W+1, event word width.
REQ-007 clk_i  input  1  clock; all state updates on its rising edge.
REQ-008 reset_i  input  1  reset, asynchronous, active-high.
REQ-009 valid_i  input  1  event word present on data_i this cycle.
REQ-010 data_i  input  WIDTH  event word, MSB to LSB {row, col, timestamp, polarity}.
REQ-011 evt_ready_i  input  1  downstream accepts the FIFO head this cycle.
REQ-012 evt_valid_o  output  1  FIFO non-empty; head event presented.
REQ-013 x_o  output  ROW_ADD  head row address.
REQ-014 y_o  output  COL_ADD  head column address.
REQ-015 ts_o  output  EPOCH_W+TS_W  head extended timestamp {epoch, timestamp}.
REQ-016 pol_o  output  1  head polarity (1 = ON, 0 = OFF).
REQ-017 overflow_o  output  1  sticky flag: at least one event dropped on full FIFO.
REQ-018 drop_cnt_o  output  8  count of events dropped on full FIFO.
REQ-019 on_cnt_o / off_cnt_o  output  16 each  counts of ON / OFF events enqueued.

Function
REQ-020 The block SHALL register data_i into a decode stage on every edge where valid_i=1; no input backpressure exists.
REQ-021 The decode stage SHALL split the word into row, col, timestamp, polarity per REQ-010.
REQ-022 The block SHALL hold last_ts (TS_W) and epoch (EPOCH_W); when a decoded event's timestamp < last_ts, epoch SHALL increment mod 2^EPOCH_W before tagging that event.
REQ-023 Each enqueued event SHALL carry ts = {epoch after REQ-022, timestamp}; last_ts SHALL update to that timestamp.
REQ-024 A decoded event SHALL be written to the FIFO on the edge following capture; latency valid_i to evt_valid_o = 2 cycles with an empty FIFO.
REQ-025 Pop SHALL occur on an edge where evt_valid_o=1 and evt_ready_i=1; head advances next cycle.
REQ-026 Simultaneous push and pop SHALL both occur, including when full (no drop) and when holding exactly one entry.
REQ-027 Push while full without pop SHALL discard the event, set overflow_o, increment drop_cnt_o saturating at 255; a dropped event SHALL NOT update last_ts, epoch or on/off counters.
REQ-028 When evt_valid_o=0, x_o, y_o, ts_o, pol_o SHALL be driven 0.
REQ-029 on_cnt_o/off_cnt_o SHALL increment per enqueued event by polarity, wrapping at 2^16.
REQ-030 FIFO order SHALL be strict first-in-first-out; pointers wrap modulo DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-031 reset_i=1 SHALL immediately clear decode stage, FIFO pointers, last_ts, epoch, all counters, overflow_o; evt_valid_o=0 and all data outputs 0.
REQ-032 Reset asserted mid-stream SHALL discard all buffered and in-flight events; first event after release behaves as after power-up.

Configuration
REQ-033 Macro EVT_DEDUP_EN defined: a decoded word bit-identical to the previously enqueued word (tracked with a valid flag cleared on reset) SHALL be discarded, not counted, and SHALL NOT affect epoch or drop_cnt_o.
REQ-034 Macro EVT_DEDUP_EN undefined: every decoded word SHALL be enqueued per REQ-024..027; no compare logic present.

Verification
REQ-035 Single event: data_i=0x5421 valid 1 cycle, evt_ready_i=1 -> 2 cycles later evt_valid_o=1 one cycle, x_o=5, y_o=2, ts_o=0x0010, pol_o=1, on_cnt_o=1.
REQ-036 Wrap: timestamps 0xF0 then 0x05 -> ts_o 0x00F0 then 0x0105.
REQ-037 Overflow: evt_ready_i=0, 6 distinct events -> 4 held, drop_cnt_o=2, overflow_o=1; then ready=1 -> first 4 events out in order.
REQ-038 Full push+pop: FIFO full, ready=1, new event -> no drop, occupancy stays 4.
REQ-039 Dedup: 0x5421 sent twice consecutively -> with EVT_DEDUP_EN one output, on_cnt_o=1; without it two outputs, on_cnt_o=2.
REQ-040 Reset mid-operation: 3 events buffered, reset_i pulse -> evt_valid_o=0, counters 0, overflow_o=0 immediately.
